// File: rtl/shift_pipe_if.sv
// Request/result handshake bundle for the pipelined barrel shifter.
// The master drives requests and consumes results; the slave is the shifter.
interface shift_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [3:0]   in_cnt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_pipe.sv
// Four-stage pipelined 16-bit barrel shifter (ROL/SLL/ROR/ASR).
// Stage k applies the 2^k shift; ready ripples back from out_ready.
module shift_pipe #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  shift_pipe_if.slave  bus
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
    logic [1:0]       op;
  } stg_t;

  stg_t             s1_q, s1_d;
  stg_t             s2_q, s2_d;
  stg_t             s3_q, s3_d;
  logic [2:0]       c1_q, c1_d;
  logic [1:0]       c2_q, c2_d;
  logic             c3_q, c3_d;
  logic             v4_q, v4_d;
  logic [WIDTH-1:0] d4_q, d4_d;

  logic adv1, adv2, adv3, adv4;
  logic ld1, ld2, ld3, ld4;

  function automatic logic [WIDTH-1:0] sh(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int               n
  );
    unique case (op)
      2'd0:    sh = (d << n) | (d >> (WIDTH - n));
      2'd1:    sh = d << n;
      2'd2:    sh = (d >> n) | (d << (WIDTH - n));
      default: sh = $unsigned($signed(d) >>> n);
    endcase
  endfunction

  // Ready chain is purely combinational so a full pipe never bubbles.
  assign adv4 = v4_q & bus.out_ready;
  assign ld4  = ~v4_q | adv4;
  assign adv3 = s3_q.v & ld4;
  assign ld3  = ~s3_q.v | adv3;
  assign adv2 = s2_q.v & ld3;
  assign ld2  = ~s2_q.v | adv2;
  assign adv1 = s1_q.v & ld2;
  assign ld1  = ~s1_q.v | adv1;

  always_comb begin
    s1_d = s1_q;
    c1_d = c1_q;
    s2_d = s2_q;
    c2_d = c2_q;
    s3_d = s3_q;
    c3_d = c3_q;
    v4_d = v4_q;
    d4_d = d4_q;
    if (ld1) begin
      s1_d.v  = bus.in_valid;
      s1_d.op = bus.in_op;
      s1_d.d  = bus.in_cnt[0] ? sh(bus.in_data, bus.in_op, 1)
                              : bus.in_data;
      c1_d    = bus.in_cnt[3:1];
    end
    if (ld2) begin
      s2_d.v  = s1_q.v;
      s2_d.op = s1_q.op;
      s2_d.d  = c1_q[0] ? sh(s1_q.d, s1_q.op, 2) : s1_q.d;
      c2_d    = c1_q[2:1];
    end
    if (ld3) begin
      s3_d.v  = s2_q.v;
      s3_d.op = s2_q.op;
      s3_d.d  = c2_q[0] ? sh(s2_q.d, s2_q.op, 4) : s2_q.d;
      c3_d    = c2_q[1];
    end
    if (ld4) begin
      v4_d = s3_q.v;
      d4_d = c3_q ? sh(s3_q.d, s3_q.op, 8) : s3_q.d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      c1_q <= '0;
      s2_q <= '0;
      c2_q <= '0;
      s3_q <= '0;
      c3_q <= '0;
      v4_q <= 1'b0;
      d4_q <= '0;
    end else begin
      s1_q <= s1_d;
      c1_q <= c1_d;
      s2_q <= s2_d;
      c2_q <= c2_d;
      s3_q <= s3_d;
      c3_q <= c3_d;
      v4_q <= v4_d;
      d4_q <= d4_d;
    end
  end

  assign bus.in_ready  = ld1;
  assign bus.out_valid = v4_q;
  assign bus.out_data  = d4_q;
  assign bus.busy      = s1_q.v | s2_q.v | s3_q.v | v4_q;

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Pipelined 16-bit barrel shifter built from four registered stages.
- Stage k shifts by 2^k when bit k of the shift count is set: stage 0 by 1, stage 1 by 2, stage 2 by 4, stage 3 by 8.
- Sits between the ALU operand mux and the writeback mux.
- Accepts one shift request per cycle over a valid/ready handshake and delivers the result 4 cycles later, with full backpressure support.

Parameters:
- WIDTH, 16, datapath width. Only 16 is supported; the stage structure is fixed to 4 stages.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  request present on in_data/in_cnt/in_op.
- in_ready  output  1  stage 1 can accept a request this cycle.
- in_data  input  16  value to shift.
- in_cnt  input  4  shift amount, 0..15.
- in_op  input  2  operation: 0=ROL, 1=SLL, 2=ROR, 3=ASR.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  16  shifted result.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Operation encoding, applied at every stage:
  - ROL: bits leaving the MSB enter at the LSB.
  - SLL: zero fill from the LSB.
  - ROR: bits leaving the LSB enter at the MSB.
  - ASR: in[15] is replicated into the vacated MSBs.
- Pipeline registers:
  - Four stage registers S1..S4.
  - Each holds valid, data[15:0], op[1:0] and the remaining count bits: S1 holds cnt[3:1], S2 holds cnt[3:2], S3 holds cnt[3].
- Stage contents:
  - S1 captures in_data shifted by 1 if in_cnt[0], else unshifted.
  - S(k+1) captures S(k).data shifted by 2^k if the carried cnt[k] is set.
  - S4 drives out_data and out_valid directly; no combinational logic after S4.
- Latency and throughput:
  - Accept at edge N; result visible on out_data after edge N+3, i.e. 4 edges including the accept.
  - Sustained throughput is 1 result/cycle when out_ready is held high.
- Advance rules:
  - adv4 = S4.valid & out_ready.
  - Stage k may load when !S(k).valid or S(k) is advancing.
  - in_ready = !S1.valid | S1 advancing.
  - The ready chain is combinational from out_ready back to in_ready; no bubble insertion is allowed.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - A stage that loads with an empty upstream clears its valid bit.
  - A stalled stage holds data, op and cnt unchanged.
- Full pipe with out_ready=1: result retires, every stage shifts down, and a new input is accepted in the same cycle.
- Full pipe with out_ready=0:
  - in_ready=0 and all stages hold.
  - in_data changes while in_ready=0 have no effect.
- out_data stays stable while out_valid=1 and out_ready=0.
- Reset:
  - rst asserted asynchronously clears all valid bits and all data, op and cnt fields to 0.
  - Outputs under reset: out_valid=0, out_data=0x0000, busy=0, in_ready=1.
  - Reset mid-operation discards every in-flight request; none emerges after release.
  - First accept is possible on the first rising edge after rst deasserts.
- in_cnt=0 passes in_data through unchanged for all four ops.
- Results are independent of in_valid timing; ordering is strictly FIFO.

Test Plan:
- Single requests, each checked after 4 cycles:
  - ROL 0x8001 cnt=1 -> 0x0003
  - SLL 0x00FF cnt=4 -> 0x0FF0
  - ROR 0x0001 cnt=15 -> 0x0002
  - ASR 0x8000 cnt=15 -> 0xFFFF
  - ASR 0x4000 cnt=3 -> 0x0800
- Passthrough: cnt=0 with data 0xA5C3 for each op -> 0xA5C3 every time.
- Streaming: 16 back-to-back SLL 0x0001 cnt=i with out_ready=1 -> results 1<<i in order, one per cycle, in_ready never drops.
- Backpressure:
  - Fill with 4 requests while out_ready=0 -> in_ready=0 from the 5th cycle on, and out_data holds the first result.
  - Then raise out_ready -> the 4 results drain in order, and a new input is accepted the same cycle the first one drains.
- Reset mid-stream: assert rst with 3 requests in flight -> out_valid=0, busy=0, out_data=0x0000 immediately; no stale result after release.
- Random ops/cnt/data with random out_ready, compared against a reference model -> full match and no drops or duplicates.
